// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a 1024x32 single-port RAM; request in N, RAM driven N+1, response N+2.
// Losing port sees ready low and must hold its request; responses cannot be stalled.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_valid,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_err,

    input  logic              d_valid,
    input  logic [31:0]       d_addr,
    input  logic              d_we,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_din,
    output logic [3:0]        m_wstrb,
    input  logic [31:0]       m_dout
);

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic              run_q, run_d;
    logic              prio_d_q, prio_d_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [31:0]       m_din_q, m_din_d;
    logic [3:0]        m_wstrb_q, m_wstrb_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_port_q, s1_port_d;
    logic              s1_err_q, s1_err_d;
    logic              s2_vld_q, s2_vld_d;
    logic              s2_port_q, s2_port_d;
    logic              s2_err_q, s2_err_d;

    logic              i_inr;
    logic              d_inr;
    logic              i_gnt;
    logic              d_gnt;
    logic              unused_addr_lsbs;

    assign i_inr = (i_addr[31:ADDR_W+2] == '0);
    assign d_inr = (d_addr[31:ADDR_W+2] == '0);
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    // run_q holds grants off until the first full clock cycle after reset release.
    always_comb begin : arb
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (run_q) begin
            if (RR) begin
                d_gnt = d_valid & (~i_valid | prio_d_q);
            end else begin
                d_gnt = d_valid;
            end
            i_gnt = i_valid & ~d_gnt;
        end
    end

    always_comb begin : nxt
        run_d     = 1'b1;
        prio_d_d  = prio_d_q;
        m_we_d    = 1'b0;
        m_addr_d  = m_addr_q;
        m_din_d   = m_din_q;
        m_wstrb_d = m_wstrb_q;
        s1_vld_d  = i_gnt | d_gnt;
        s1_port_d = d_gnt ? PORT_D : PORT_I;
        s1_err_d  = d_gnt ? ~d_inr : ~i_inr;
        s2_vld_d  = s1_vld_q;
        s2_port_d = s1_port_q;
        s2_err_d  = s1_err_q;
        if (i_gnt) begin
            m_addr_d = i_addr[ADDR_W+1:2];
            prio_d_d = 1'b1;
        end
        if (d_gnt) begin
            m_addr_d  = d_addr[ADDR_W+1:2];
            m_din_d   = d_wdata;
            m_wstrb_d = d_wstrb;
            m_we_d    = d_we & d_inr;
            prio_d_d  = 1'b0;
        end
    end

    // Async reset also kills an in-flight write strobe before the next RAM edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            prio_d_q  <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_din_q   <= '0;
            m_wstrb_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_port_q <= PORT_I;
            s1_err_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_port_q <= PORT_I;
            s2_err_q  <= 1'b0;
        end else begin
            run_q     <= run_d;
            prio_d_q  <= prio_d_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_din_q   <= m_din_d;
            m_wstrb_q <= m_wstrb_d;
            s1_vld_q  <= s1_vld_d;
            s1_port_q <= s1_port_d;
            s1_err_q  <= s1_err_d;
            s2_vld_q  <= s2_vld_d;
            s2_port_q <= s2_port_d;
            s2_err_q  <= s2_err_d;
        end
    end

    assign i_ready  = i_gnt;
    assign d_ready  = d_gnt;

    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_din    = m_din_q;
    assign m_wstrb  = m_wstrb_q;

    // RAM output is already the post-write word for stores, so both response kinds read m_dout.
    assign i_rvalid = s2_vld_q & (s2_port_q == PORT_I);
    assign d_rvalid = s2_vld_q & (s2_port_q == PORT_D);
    assign i_err    = i_rvalid & s2_err_q;
    assign d_err    = d_rvalid & s2_err_q;
    assign i_rdata  = (i_rvalid && !s2_err_q) ? m_dout : 32'h0;
    assign d_rdata  = (d_rvalid && !s2_err_q) ? m_dout : 32'h0;

    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(i_ready && d_ready));
    a_one_resp:  assert property (@(posedge clk) disable iff (!rst_n) !(i_rvalid && d_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RR=1 instance checked by a per-cycle vector table, RR=0 instance for priority.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        d_valid;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;

    logic        i_ready, i_rvalid, i_err, d_ready, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_din, m_dout;
    logic [3:0]  m_wstrb;

    logic        z_i_ready, z_i_rvalid, z_i_err, z_d_ready, z_d_rvalid, z_d_err;
    logic [31:0] z_i_rdata, z_d_rdata;
    logic        z_m_we;
    logic [9:0]  z_m_addr;
    logic [31:0] z_m_din, z_m_dout;
    logic [3:0]  z_m_wstrb;

    mem_arbiter #(.ADDR_W(10), .RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_valid(d_valid), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_wstrb(m_wstrb), .m_dout(m_dout)
    );

    mem_arbiter #(.ADDR_W(10), .RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(z_i_ready),
        .i_rvalid(z_i_rvalid), .i_rdata(z_i_rdata), .i_err(z_i_err),
        .d_valid(d_valid), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(z_d_ready), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata), .d_err(z_d_err),
        .m_we(z_m_we), .m_addr(z_m_addr), .m_din(z_m_din), .m_wstrb(z_m_wstrb), .m_dout(z_m_dout)
    );

    // Behavioural RAMs: write-first, registered read address, plus a preload port.
    logic [31:0] mem1 [1024];
    logic [31:0] mem0 [1024];
    logic [9:0]  ra1_q, ra0_q;
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_dat;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (pl_en) mem1[pl_addr] <= pl_dat;
        else if (m_we) mem1[m_addr] <= merge(mem1[m_addr], m_din, m_wstrb);
        ra1_q <= m_addr;
    end
    always @(posedge clk) begin
        if (pl_en) mem0[pl_addr] <= pl_dat;
        else if (z_m_we) mem0[z_m_addr] <= merge(mem0[z_m_addr], z_m_din, z_m_wstrb);
        ra0_q <= z_m_addr;
    end
    assign m_dout   = mem1[ra1_q];
    assign z_m_dout = mem0[ra0_q];

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic        dwe;
        logic [31:0] dwd;
        logic [3:0]  dws;
        logic        e_ir;
        logic        e_dr;
        logic        e_we;
        logic [9:0]  e_ma;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_ier;
        logic        e_drv;
        logic [31:0] e_drd;
        logic        e_der;
    } vec_t;

    localparam logic        L0 = 1'b0;
    localparam logic        L1 = 1'b1;
    localparam logic [31:0] Z  = 32'h0;
    localparam int          NV = 18;
    vec_t tbl [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{L1, 32'h0,        L0, Z,        L0, Z,            4'h0, L1, L0, L0, 10'd0,    L0, Z,            L0, L0, Z,            L0};
        tbl[1]  = '{L1, 32'h4,        L0, Z,        L0, Z,            4'h0, L1, L0, L0, 10'd0,    L0, Z,            L0, L0, Z,            L0};
        tbl[2]  = '{L1, 32'h8,        L0, Z,        L0, Z,            4'h0, L1, L0, L0, 10'd1,    L1, 32'h3fc00093, L0, L0, Z,            L0};
        tbl[3]  = '{L0, Z,            L0, Z,        L0, Z,            4'h0, L0, L0, L0, 10'd2,    L1, 32'h0000a023, L0, L0, Z,            L0};
        tbl[4]  = '{L0, Z,            L1, 32'h3fc,  L1, 32'h11223344, 4'h5, L0, L1, L0, 10'd2,    L1, 32'h0000a103, L0, L0, Z,            L0};
        tbl[5]  = '{L0, Z,            L1, 32'h3fc,  L0, Z,            4'h0, L0, L1, L1, 10'd255,  L0, Z,            L0, L0, Z,            L0};
        tbl[6]  = '{L0, Z,            L0, Z,        L0, Z,            4'h0, L0, L0, L0, 10'd255,  L0, Z,            L0, L1, 32'h00220044, L0};
        tbl[7]  = '{L0, Z,            L0, Z,        L0, Z,            4'h0, L0, L0, L0, 10'd255,  L0, Z,            L0, L1, 32'h00220044, L0};
        tbl[8]  = '{L1, 32'h0,        L1, 32'h10,   L0, Z,            4'h0, L1, L0, L0, 10'd255,  L0, Z,            L0, L0, Z,            L0};
        tbl[9]  = '{L1, 32'h4,        L1, 32'h10,   L0, Z,            4'h0, L0, L1, L0, 10'd0,    L0, Z,            L0, L0, Z,            L0};
        tbl[10] = '{L1, 32'h4,        L1, 32'h10,   L0, Z,            4'h0, L1, L0, L0, 10'd4,    L1, 32'h3fc00093, L0, L0, Z,            L0};
        tbl[11] = '{L1, 32'h8,        L1, 32'h10,   L0, Z,            4'h0, L0, L1, L0, 10'd1,    L0, Z,            L0, L1, 32'hdeadbeef, L0};
        tbl[12] = '{L1, 32'h8,        L1, 32'h1000, L1, 32'hffffffff, 4'hf, L1, L0, L0, 10'd4,    L1, 32'h0000a023, L0, L0, Z,            L0};
        tbl[13] = '{L0, Z,            L1, 32'h1000, L1, 32'hffffffff, 4'hf, L0, L1, L0, 10'd2,    L0, Z,            L0, L1, 32'hdeadbeef, L0};
        tbl[14] = '{L1, 32'hfffffffc, L0, Z,        L0, Z,            4'h0, L1, L0, L0, 10'd0,    L1, 32'h0000a103, L0, L0, Z,            L0};
        tbl[15] = '{L0, Z,            L0, Z,        L0, Z,            4'h0, L0, L0, L0, 10'd1023, L0, Z,            L0, L1, Z,            L1};
        tbl[16] = '{L0, Z,            L0, Z,        L0, Z,            4'h0, L0, L0, L0, 10'd1023, L1, Z,            L1, L0, Z,            L0};
        tbl[17] = '{L0, Z,            L0, Z,        L0, Z,            4'h0, L0, L0, L0, 10'd1023, L0, Z,            L0, L0, Z,            L0};

        rst_n = 1'b1; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0;
        d_we = 1'b0; d_wdata = '0; d_wstrb = '0; pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
        #1 rst_n = 1'b0;

        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            pl_en = 1'b1;
            case (p)
                0: begin pl_addr = 10'd0;   pl_dat = 32'h3fc00093; end
                1: begin pl_addr = 10'd1;   pl_dat = 32'h0000a023; end
                2: begin pl_addr = 10'd2;   pl_dat = 32'h0000a103; end
                3: begin pl_addr = 10'd4;   pl_dat = 32'hdeadbeef; end
                4: begin pl_addr = 10'd8;   pl_dat = 32'h12345678; end
                default: begin pl_addr = 10'd255; pl_dat = 32'h0; end
            endcase
        end
        @(negedge clk);
        pl_en = 1'b0;
        i_valid = 1'b1;
        #1;
        chk1("rst i_ready", i_ready, 1'b0);
        chk1("rst m_we", m_we, 1'b0);
        chk32("rst m_addr", {22'h0, m_addr}, 32'h0);
        chk32("rst m_din", m_din, 32'h0);
        chk32("rst m_wstrb", {28'h0, m_wstrb}, 32'h0);
        chk1("rst i_rvalid", i_rvalid, 1'b0);
        chk1("rst d_rvalid", d_rvalid, 1'b0);
        chk1("rst i_err", i_err, 1'b0);
        chk1("rst d_err", d_err, 1'b0);
        chk32("rst i_rdata", i_rdata, 32'h0);
        chk32("rst d_rdata", d_rdata, 32'h0);
        i_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            i_valid = tbl[k].iv;  i_addr = tbl[k].ia;
            d_valid = tbl[k].dv;  d_addr = tbl[k].da;  d_we = tbl[k].dwe;
            d_wdata = tbl[k].dwd; d_wstrb = tbl[k].dws;
            #1;
            chk1($sformatf("v%0d i_ready", k), i_ready, tbl[k].e_ir);
            chk1($sformatf("v%0d d_ready", k), d_ready, tbl[k].e_dr);
            chk1($sformatf("v%0d m_we", k), m_we, tbl[k].e_we);
            chk32($sformatf("v%0d m_addr", k), {22'h0, m_addr}, {22'h0, tbl[k].e_ma});
            chk1($sformatf("v%0d i_rvalid", k), i_rvalid, tbl[k].e_irv);
            chk1($sformatf("v%0d d_rvalid", k), d_rvalid, tbl[k].e_drv);
            if (tbl[k].e_irv) begin
                chk32($sformatf("v%0d i_rdata", k), i_rdata, tbl[k].e_ird);
                chk1($sformatf("v%0d i_err", k), i_err, tbl[k].e_ier);
            end
            if (tbl[k].e_drv) begin
                chk32($sformatf("v%0d d_rdata", k), d_rdata, tbl[k].e_drd);
                chk1($sformatf("v%0d d_err", k), d_err, tbl[k].e_der);
            end
        end
        chk32("ram word 255 after store", mem1[255], 32'h00220044);
        chk32("ram word 0 after oor store", mem1[0], 32'h3fc00093);

        // Fixed-priority instance: data wins every contended cycle.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            i_valid = (c < 4); i_addr = 32'h0;
            d_valid = (c < 4); d_addr = 32'h10; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
            #1;
            if (c < 4) begin
                chk1($sformatf("fp%0d i_ready", c), z_i_ready, 1'b0);
                chk1($sformatf("fp%0d d_ready", c), z_d_ready, 1'b1);
            end
            chk1($sformatf("fp%0d i_rvalid", c), z_i_rvalid, 1'b0);
            chk1($sformatf("fp%0d d_rvalid", c), z_d_rvalid, (c >= 2 && c < 6));
            if (c >= 2 && c < 6) chk32($sformatf("fp%0d d_rdata", c), z_d_rdata, 32'hdeadbeef);
        end

        // Reset lands the cycle after a store is accepted.
        @(negedge clk);
        d_valid = 1'b1; d_addr = 32'h20; d_we = 1'b1; d_wdata = 32'h55555555; d_wstrb = 4'hf;
        #1 chk1("mf d_ready", d_ready, 1'b1);
        @(posedge clk);
        #1;
        d_valid = 1'b0; d_we = 1'b0;
        chk1("mf m_we before reset", m_we, 1'b1);
        chk32("mf m_addr", {22'h0, m_addr}, 32'h8);
        chk32("mf m_din", m_din, 32'h55555555);
        chk32("mf m_wstrb", {28'h0, m_wstrb}, 32'hf);
        #1 rst_n = 1'b0;
        #1;
        chk1("mf m_we after reset", m_we, 1'b0);
        chk1("mf fp m_we after reset", z_m_we, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("mf%0d d_rvalid", c), d_rvalid, 1'b0);
            chk1($sformatf("mf%0d fp d_rvalid", c), z_d_rvalid, 1'b0);
        end
        chk32("mf ram word 8", mem1[8], 32'h12345678);
        chk32("mf fp ram word 8", mem0[8], 32'h12345678);
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b1; i_addr = 32'h20;
        #1 chk1("post i_ready", i_ready, 1'b1);
        @(negedge clk);
        i_valid = 1'b0;
        #1 chk1("post i_rvalid n+1", i_rvalid, 1'b0);
        @(negedge clk);
        #1;
        chk1("post i_rvalid n+2", i_rvalid, 1'b1);
        chk32("post i_rdata", i_rdata, 32'h12345678);
        chk1("post i_err", i_err, 1'b0);
        @(negedge clk);
        #1 chk1("post i_rvalid n+3", i_rvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 4 KB system RAM (1024 x 32, byte write strobes, registered read address) between the RV32I core's instruction-fetch port and load/store port. It converts byte addresses to word indices, grants one request per cycle by round-robin (or fixed priority), and drives the RAM's we/addr/din/wstrb through registers. It returns each response with a fixed 2-cycle latency and tags it to the requesting port. It sits between the HLS core and the memory; out-of-range accesses are suppressed and flagged.

## Interface
- ADDR_W, 10, word-index width (RAM depth = 2**ADDR_W words)
- RR, 1, 1 = round-robin between ports; 0 = fixed priority, data port wins
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  fetch request valid
- i_addr  input  32  fetch byte address
- i_ready  output  1  fetch request accepted this cycle
- i_rvalid  output  1  fetch response valid
- i_rdata  output  32  fetch read data
- i_err  output  1  fetch response is out-of-range
- d_valid  input  1  data request valid
- d_addr  input  32  data byte address
- d_we  input  1  1 = store, 0 = load
- d_wdata  input  32  store data
- d_wstrb  input  4  store byte enables
- d_ready  output  1  data request accepted this cycle
- d_rvalid  output  1  data response valid (loads and stores)
- d_rdata  output  32  data read data
- d_err  output  1  data response is out-of-range
- m_we  output  1  RAM write enable
- m_addr  output  ADDR_W  RAM word address
- m_din  output  32  RAM write data
- m_wstrb  output  4  RAM byte strobes
- m_dout  input  32  RAM read data (valid the cycle after the address is sampled)

## Operation
- Word index = addr[ADDR_W+1:2]; addr[1:0] is ignored. An address is in range iff addr[31:ADDR_W+2] == 0.
- Arbitration is combinational: i_ready/d_ready assert in the same cycle as valid. At most one of them is high per cycle.
  - RR=1, both valid: grant the port not granted most recently. Pointer updates only on an actual grant. After reset, fetch has priority.
  - RR=0: data port always wins; fetch is granted only when d_valid=0.
  - Single valid: that port is granted.
- Throughput: one accepted request per cycle; back-to-back accesses are fully pipelined.
- Pipeline:
  - Stage 1 register: m_addr, m_din, m_wstrb, m_we, plus tag {port, err}.
  - m_we = d_we & in-range for a granted data request; 0 for fetch, loads, or out-of-range.
  - Stage 2 register: tag only.
- Response in stage 2: x_rvalid = 1 for the tagged port. x_rdata = m_dout, or 0 if err. x_err = err.
- Store response rdata = post-write contents of the addressed word, all 4 bytes; unstrobed bytes are unchanged.
- No response backpressure: requesters must accept rvalid when it arrives.
- Non-granted requests must hold valid and address until ready; the block does not latch them.
- m_addr/m_din/m_wstrb hold their last values when idle; only m_we is pulsed.

## Timing
- Reset values: m_we=0, m_addr=0, m_din=0, m_wstrb=0, i_rvalid=d_rvalid=0, i_err=d_err=0, i_rdata=d_rdata=0, RR pointer = fetch.
- Request accepted in cycle N:
  - m_* is driven in N+1; the RAM samples it at the end of N+1.
  - rvalid is high in N+2 only.
  - Latency is exactly 2 cycles for every access, hit or error.
- m_we is high for exactly one cycle per in-range store.
- A store in N followed by a load of the same word in N+1: the load sees the new data. RAM write and read address update on the same edge.
- Reset assertion mid-operation:
  - m_we drops asynchronously; no write occurs after rst_n falls.
  - In-flight stage-1/stage-2 tags are cleared; no rvalid is issued for them.
- Reset deassertion: requests are granted starting the first full cycle with rst_n=1.

## Test plan
- Fetch-only: i_addr=0x0, 0x4, 0x8 back-to-back with RAM preloaded 0x3fc00093, 0x0000a023, 0x0000a103 -> i_ready=1 each cycle; i_rvalid in N+2, N+3, N+4 with those words; i_err=0.
- Store/load: d_we=1, d_addr=0x3fc, d_wdata=0x11223344, d_wstrb=4'b0101, then a load of 0x3fc, old word 0 -> m_we pulse with m_addr=255; store rdata=0x00220044; load rdata=0x00220044 two cycles later.
- Contention, RR=1: both valid for 4 cycles -> grants alternate I, D, I, D; rvalids alternate accordingly. Same stimulus with RR=0 -> D for all 4 cycles, i_ready=0 throughout.
- Out-of-range: d_we=1, d_addr=0x1000 -> m_we stays 0, RAM unchanged, d_err=1, d_rdata=0 in N+2. Fetch of 0xFFFF_FFFC -> i_err=1.
- Reset mid-flight: assert rst_n=0 in the cycle after a store is accepted -> m_we falls immediately, no rvalid, target word unchanged. After release, the first request completes normally in 2 cycles.
